// File: rtl/wptr_handler_if.sv
// Write-side pointer handler bus: write request, synchronised read pointer,
// overflow clear, and the pointer/flag outputs of the write domain.
// The master drives requests; the slave (wptr_handler) drives pointers and flags.
interface wptr_handler_if #(
  parameter int PTR_WIDTH = 6
);
  logic                 w_en;
  logic [PTR_WIDTH:0]   g_rptr_sync;
  logic                 ovf_clr;
  logic                 w_accept;
  logic [PTR_WIDTH:0]   b_wptr;
  logic [PTR_WIDTH:0]   g_wptr;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH:0]   wr_level;
  logic                 overflow;

  modport master (
    output w_en, g_rptr_sync, ovf_clr,
    input  w_accept, b_wptr, g_wptr, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  w_en, g_rptr_sync, ovf_clr,
    output w_accept, b_wptr, g_wptr, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/wptr_handler.sv
// Write-domain pointer and flag logic of an asynchronous FIFO.
// Holds binary and Gray write pointers plus registered full, almost_full and
// fill level, all computed against the read Gray pointer that has already been
// synchronised into wclk. Full and level include the write accepted on the
// same edge, so the write side sees no lag of its own.
// Optional feature: define WPTR_OVERFLOW_EN to get a sticky overflow flag
// cleared by ovf_clr; otherwise overflow is tied low and ovf_clr is ignored.
module wptr_handler #(
  parameter int PTR_WIDTH = 6,
  parameter int AF_THRESH = 2**PTR_WIDTH - 8
) (
  input  logic           wclk,
  input  logic           rst,
  wptr_handler_if.slave  wif
);

  localparam logic [PTR_WIDTH:0] AF_LVL = (PTR_WIDTH+1)'(AF_THRESH);

  logic [PTR_WIDTH:0] b_wptr_q;
  logic [PTR_WIDTH:0] g_wptr_q;
  logic [PTR_WIDTH:0] level_q;
  logic               full_q;
  logic               af_q;

  logic               w_accept;
  logic [PTR_WIDTH:0] b_next;
  logic [PTR_WIDTH:0] g_next;
  logic [PTR_WIDTH:0] rbin;
  logic [PTR_WIDTH:0] lvl_next;
  logic [PTR_WIDTH:0] g_full_pat;
  logic               full_next;
  logic               af_next;

  // A write is only taken while not full; this is also the memory write strobe.
  assign w_accept = wif.w_en & ~full_q;

  assign b_next = b_wptr_q + {{PTR_WIDTH{1'b0}}, w_accept};
  assign g_next = (b_next >> 1) ^ b_next;

  // Gray-to-binary of the synchronised read pointer: each bit is the XOR of
  // itself and every Gray bit above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) begin
      rbin[i] = ^(wif.g_rptr_sync >> i);
    end
  end

  // Modular difference stays correct when either pointer wraps.
  assign lvl_next = b_next - rbin;

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that is the top two bits inverted and the rest equal.
  assign g_full_pat = {~wif.g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                       wif.g_rptr_sync[PTR_WIDTH-2:0]};
  assign full_next  = (g_next == g_full_pat);
  assign af_next    = (lvl_next >= AF_LVL);

  // Register pointers, level and flags; async active-low reset clears them all.
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      b_wptr_q <= b_next;
      g_wptr_q <= g_next;
      level_q  <= lvl_next;
      full_q   <= full_next;
      af_q     <= af_next;
    end
  end

`ifdef WPTR_OVERFLOW_EN
  logic ovf_q;

  // Sticky overflow: a dropped write sets it, ovf_clr clears it, set wins.
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (wif.w_en & full_q) begin
      ovf_q <= 1'b1;
    end else if (wif.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign wif.overflow = ovf_q;
`else
  assign wif.overflow = 1'b0;
`endif

  assign wif.w_accept    = w_accept;
  assign wif.b_wptr      = b_wptr_q;
  assign wif.g_wptr      = g_wptr_q;
  assign wif.wr_level    = level_q;
  assign wif.full        = full_q;
  assign wif.almost_full = af_q;

endmodule
